// File: rtl/button_event_scheduler.sv
// Keypad front end: synchronizes digit/confirm/shuffle keys, classifies confirm as
// short or long, arbitrates one event per cycle and queues it in a fall-through FIFO.
module button_event_scheduler #(
    parameter int LONG_PRESS_CYCLES = 64,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] digit_buttons,
    input  logic       confirm_button,
    input  logic       shuffle_button,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [3:0] evt_code,
    output logic       evt_dropped,
    output logic       confirm_held
);
    localparam int CNT_W = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FIFO_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [3:0] CODE_CONF_SHORT = 4'd10;
    localparam logic [3:0] CODE_CONF_LONG  = 4'd11;
    localparam logic [3:0] CODE_SHUFFLE    = 4'd12;

    typedef enum logic [1:0] {CONF_IDLE, CONF_HELD, CONF_LONG_WAIT} conf_state_e;

    // Bit layout of the synchronized vector: [9:0] digits, [10] confirm, [11] shuffle
    logic [11:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [11:0]      rise;
    conf_state_e      conf_state_q, conf_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conf_vld;
    logic [3:0]       conf_code;
    logic [3:0]       dig_code;
    logic             dig_any, dig_multi, dig_found;
    logic             win_vld, lost;
    logic [3:0]       win_code;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             dropped_q, dropped_d;
    logic             push, pop, full;

    always_comb begin
        sync1_d = {shuffle_button, confirm_button, digit_buttons};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;

        conf_state_d = conf_state_q;
        cnt_d        = cnt_q;
        conf_vld     = 1'b0;
        conf_code    = 4'd0;
        unique case (conf_state_q)
            CONF_IDLE: begin
                if (rise[10]) begin
                    conf_state_d = CONF_HELD;
                    cnt_d        = CNT_ONE;
                end
            end
            CONF_HELD: begin
                if (sync2_q[10]) begin
                    if (cnt_q == CNT_LAST) begin
                        conf_vld     = 1'b1;
                        conf_code    = CODE_CONF_LONG;
                        conf_state_d = CONF_LONG_WAIT;
                        cnt_d        = CNT_SAT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    conf_vld     = 1'b1;
                    conf_code    = CODE_CONF_SHORT;
                    conf_state_d = CONF_IDLE;
                    cnt_d        = '0;
                end
            end
            CONF_LONG_WAIT: begin
                if (!sync2_q[10]) begin
                    conf_state_d = CONF_IDLE;
                    cnt_d        = '0;
                end
            end
            default: begin
                conf_state_d = CONF_IDLE;
                cnt_d        = '0;
            end
        endcase

        dig_code  = 4'd0;
        dig_found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rise[i] && !dig_found) begin
                dig_code  = 4'(i);
                dig_found = 1'b1;
            end
        end
        dig_any   = |rise[9:0];
        dig_multi = |(rise[9:0] & (rise[9:0] - 10'd1));

        // Priority: confirm > shuffle > lowest digit; any second candidate is a loss
        win_vld  = conf_vld | rise[11] | dig_any;
        win_code = conf_vld ? conf_code : (rise[11] ? CODE_SHUFFLE : dig_code);
        lost     = (conf_vld & (rise[11] | dig_any)) | (rise[11] & dig_any) | dig_multi;

        pop  = evt_valid & evt_ready;
        full = (count_q == CNT_FULL);
        push = win_vld & (~full | pop);
        dropped_d = lost | (win_vld & ~push);

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + FIFO_ONE;
            2'b01:   count_d = count_q - FIFO_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            conf_state_q <= CONF_IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dropped_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            conf_state_q <= conf_state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dropped_q    <= dropped_d;
        end
    end

    // Queue storage needs no reset: the head is masked to 0 while the FIFO is empty
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= win_code;
        end
    end

    assign evt_valid    = (count_q != '0);
    assign evt_code     = evt_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign evt_dropped  = dropped_q;
    assign confirm_held = sync2_q[10];

endmodule
